// File: rtl/alu_arbiter_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
// Holds the FSM state encoding, requester index type and operand control bundle.
package alu_arbiter_pkg;

    localparam int DATA_WIDTH_DEFAULT = 32;
    localparam int NUM_REQ            = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef logic [0:0] req_idx_t;

    typedef struct packed {
        logic       funct7;
        logic [2:0] alu_op;
        logic [2:0] funct3;
    } alu_ctrl_t;

    function automatic req_idx_t onehot_to_idx(input logic [NUM_REQ-1:0] onehot);
        req_idx_t idx;
        idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (onehot[i]) begin
                idx = req_idx_t'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Bundle of request, response and shared-ALU signals around the arbiter.
// slave is the arbiter side; master is the requester/ALU environment side.
interface alu_arbiter_if
    import alu_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
);

    logic                  req0_valid_i;
    logic                  req0_ready_o;
    logic [DATA_WIDTH-1:0] req0_a_i;
    logic [DATA_WIDTH-1:0] req0_b_i;
    logic                  req0_funct7_i;
    logic [2:0]            req0_alu_op_i;
    logic [2:0]            req0_funct3_i;

    logic                  req1_valid_i;
    logic                  req1_ready_o;
    logic [DATA_WIDTH-1:0] req1_a_i;
    logic [DATA_WIDTH-1:0] req1_b_i;
    logic                  req1_funct7_i;
    logic [2:0]            req1_alu_op_i;
    logic [2:0]            req1_funct3_i;

    logic                  rsp0_valid_o;
    logic                  rsp0_ready_i;
    logic [DATA_WIDTH-1:0] rsp0_data_o;
    logic                  rsp0_zero_o;

    logic                  rsp1_valid_o;
    logic                  rsp1_ready_i;
    logic [DATA_WIDTH-1:0] rsp1_data_o;
    logic                  rsp1_zero_o;

    logic [DATA_WIDTH-1:0] alu_a_o;
    logic [DATA_WIDTH-1:0] alu_b_o;
    logic                  alu_funct7_o;
    logic [2:0]            alu_op_o;
    logic [2:0]            alu_funct3_o;
    logic [DATA_WIDTH-1:0] alu_result_i;
    logic                  alu_zero_i;

    modport slave (
        input  req0_valid_i, req0_a_i, req0_b_i, req0_funct7_i, req0_alu_op_i, req0_funct3_i,
        input  req1_valid_i, req1_a_i, req1_b_i, req1_funct7_i, req1_alu_op_i, req1_funct3_i,
        output req0_ready_o, req1_ready_o,
        output rsp0_valid_o, rsp0_data_o, rsp0_zero_o,
        output rsp1_valid_o, rsp1_data_o, rsp1_zero_o,
        input  rsp0_ready_i, rsp1_ready_i,
        output alu_a_o, alu_b_o, alu_funct7_o, alu_op_o, alu_funct3_o,
        input  alu_result_i, alu_zero_i
    );

    modport master (
        output req0_valid_i, req0_a_i, req0_b_i, req0_funct7_i, req0_alu_op_i, req0_funct3_i,
        output req1_valid_i, req1_a_i, req1_b_i, req1_funct7_i, req1_alu_op_i, req1_funct3_i,
        input  req0_ready_o, req1_ready_o,
        input  rsp0_valid_o, rsp0_data_o, rsp0_zero_o,
        input  rsp1_valid_o, rsp1_data_o, rsp1_zero_o,
        output rsp0_ready_i, rsp1_ready_i,
        input  alu_a_o, alu_b_o, alu_funct7_o, alu_op_o, alu_funct3_o,
        output alu_result_i, alu_zero_i
    );

endinterface

// File: rtl/alu_arb_rr.sv
// Two-way round-robin grant: a lone valid always wins, a tie goes to ptr.
// Purely combinational; the caller owns and advances the pointer.
module alu_arb_rr
    import alu_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] valid,
    input  req_idx_t           ptr,
    output logic [NUM_REQ-1:0] grant
);

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_grant
            localparam int OTHER = NUM_REQ - 1 - gi;
            assign grant[gi] = valid[gi] && (!valid[OTHER] || (ptr == req_idx_t'(gi)));
        end
    endgenerate

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one shared combinational ALU, one transaction at a time.
// IDLE grants and latches operands, EXEC captures the ALU return, RESP holds it until consumed.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    alu_arbiter_if.slave bus
);

    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    rsp_ready;
    logic [NUM_REQ-1:0]    grant;
    logic [DATA_WIDTH-1:0] req_a    [NUM_REQ];
    logic [DATA_WIDTH-1:0] req_b    [NUM_REQ];
    alu_ctrl_t             req_ctrl [NUM_REQ];

    state_t                state_reg;
    req_idx_t              ptr_reg;
    req_idx_t              grant_reg;
    logic [DATA_WIDTH-1:0] a_reg;
    logic [DATA_WIDTH-1:0] b_reg;
    alu_ctrl_t             ctrl_reg;
    logic [DATA_WIDTH-1:0] res_data_reg;
    logic                  res_zero_reg;

    req_idx_t              grant_idx;
    logic                  in_idle;
    logic [NUM_REQ-1:0]    rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_data [NUM_REQ];
    logic [NUM_REQ-1:0]    rsp_zero;

    assign req_valid   = {bus.req1_valid_i, bus.req0_valid_i};
    assign rsp_ready   = {bus.rsp1_ready_i, bus.rsp0_ready_i};
    assign req_a[0]    = bus.req0_a_i;
    assign req_a[1]    = bus.req1_a_i;
    assign req_b[0]    = bus.req0_b_i;
    assign req_b[1]    = bus.req1_b_i;
    assign req_ctrl[0] = '{funct7: bus.req0_funct7_i, alu_op: bus.req0_alu_op_i, funct3: bus.req0_funct3_i};
    assign req_ctrl[1] = '{funct7: bus.req1_funct7_i, alu_op: bus.req1_alu_op_i, funct3: bus.req1_funct3_i};

    alu_arb_rr u_rr (
        .valid (req_valid),
        .ptr   (ptr_reg),
        .grant (grant)
    );

    assign grant_idx = onehot_to_idx(grant);

    // Ready is a same-cycle acknowledgement, so it is gated by reset as well as state.
    assign in_idle          = (state_reg == IDLE) && !reset;
    assign bus.req0_ready_o = in_idle && grant[0];
    assign bus.req1_ready_o = in_idle && grant[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            ptr_reg      <= '0;
            grant_reg    <= '0;
            a_reg        <= '0;
            b_reg        <= '0;
            ctrl_reg     <= '0;
            res_data_reg <= '0;
            res_zero_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (|grant) begin
                        a_reg     <= req_a[grant_idx];
                        b_reg     <= req_b[grant_idx];
                        ctrl_reg  <= req_ctrl[grant_idx];
                        grant_reg <= grant_idx;
                        ptr_reg   <= ~grant_idx;
                        state_reg <= EXEC;
                    end
                end
                EXEC: begin
                    res_data_reg <= bus.alu_result_i;
                    res_zero_reg <= bus.alu_zero_i;
                    state_reg    <= RESP;
                end
                RESP: begin
                    if (rsp_ready[grant_reg]) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // The shared ALU only ever sees the latched operands, never the live request inputs.
    assign bus.alu_a_o      = a_reg;
    assign bus.alu_b_o      = b_reg;
    assign bus.alu_funct7_o = ctrl_reg.funct7;
    assign bus.alu_op_o     = ctrl_reg.alu_op;
    assign bus.alu_funct3_o = ctrl_reg.funct3;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rsp
            assign rsp_valid[gi] = (state_reg == RESP) && (grant_reg == req_idx_t'(gi));
            assign rsp_data[gi]  = rsp_valid[gi] ? res_data_reg : '0;
            assign rsp_zero[gi]  = rsp_valid[gi] && res_zero_reg;
        end
    endgenerate

    assign bus.rsp0_valid_o = rsp_valid[0];
    assign bus.rsp0_data_o  = rsp_data[0];
    assign bus.rsp0_zero_o  = rsp_zero[0];
    assign bus.rsp1_valid_o = rsp_valid[1];
    assign bus.rsp1_data_o  = rsp_data[1];
    assign bus.rsp1_zero_o  = rsp_zero[1];

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter with a scoreboard of expected responses.
// The shared ALU is modelled here as add (funct7=0) or subtract (funct7=1).
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    localparam int DW = 32;

    typedef struct {
        int          idx;
        logic [DW-1:0] data;
        logic        zero;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb [$];

    always #5 clk = ~clk;

    alu_arbiter_if #(.DATA_WIDTH(DW)) bus ();

    alu_arbiter #(.DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.alu_result_i = bus.alu_funct7_o ? (bus.alu_a_o - bus.alu_b_o) : (bus.alu_a_o + bus.alu_b_o);
    assign bus.alu_zero_i   = (bus.alu_result_i == '0);

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        bus.req0_valid_i = 1'b0; bus.req0_a_i = '0; bus.req0_b_i = '0;
        bus.req0_funct7_i = 1'b0; bus.req0_alu_op_i = 3'b000; bus.req0_funct3_i = 3'b000;
        bus.req1_valid_i = 1'b0; bus.req1_a_i = '0; bus.req1_b_i = '0;
        bus.req1_funct7_i = 1'b0; bus.req1_alu_op_i = 3'b000; bus.req1_funct3_i = 3'b000;
    endtask

    task automatic drive_req(input int idx, input logic [DW-1:0] a, input logic [DW-1:0] b, input logic f7);
        if (idx == 0) begin
            bus.req0_valid_i = 1'b1; bus.req0_a_i = a; bus.req0_b_i = b; bus.req0_funct7_i = f7;
            bus.req0_alu_op_i = 3'b000; bus.req0_funct3_i = 3'b000;
        end else begin
            bus.req1_valid_i = 1'b1; bus.req1_a_i = a; bus.req1_b_i = b; bus.req1_funct7_i = f7;
            bus.req1_alu_op_i = 3'b000; bus.req1_funct3_i = 3'b000;
        end
    endtask

    function automatic logic get_rsp_valid(input int idx);
        return (idx == 0) ? bus.rsp0_valid_o : bus.rsp1_valid_o;
    endfunction

    function automatic logic [DW-1:0] get_rsp_data(input int idx);
        return (idx == 0) ? bus.rsp0_data_o : bus.rsp1_data_o;
    endfunction

    function automatic logic get_rsp_zero(input int idx);
        return (idx == 0) ? bus.rsp0_zero_o : bus.rsp1_zero_o;
    endfunction

    // Advances up to budget cycles until requester idx sees rsp_valid; ok tells whether it did.
    task automatic wait_rsp(input int idx, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (get_rsp_valid(idx)) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_reqs();
        bus.rsp0_ready_i = 1'b1;
        bus.rsp1_ready_i = 1'b1;
        drive_req(0, 32'd11, 32'd22, 1'b0);
        drive_req(1, 32'd33, 32'd44, 1'b1);
        tick();
        tick();
        n_checks++;
        if ({bus.req1_ready_o, bus.req0_ready_o} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_ready: got %b, expected 00", {bus.req1_ready_o, bus.req0_ready_o});
        end
        n_checks++;
        if ({bus.rsp1_valid_o, bus.rsp0_valid_o, bus.rsp0_data_o, bus.rsp1_data_o, bus.rsp0_zero_o, bus.rsp1_zero_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_rsp: valid=%b%b data0=%h data1=%h, expected all 0",
                     bus.rsp1_valid_o, bus.rsp0_valid_o, bus.rsp0_data_o, bus.rsp1_data_o);
        end
        n_checks++;
        if ({bus.alu_a_o, bus.alu_b_o, bus.alu_funct7_o, bus.alu_op_o, bus.alu_funct3_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_alu: a=%h b=%h, expected 0", bus.alu_a_o, bus.alu_b_o);
        end
        clear_reqs();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single_req0();
        exp_t e;
        drive_req(0, 32'd5, 32'd3, 1'b0);
        #1;
        n_checks++;
        if ({bus.req1_ready_o, bus.req0_ready_o} !== 2'b01) begin
            n_fail++;
            $display("FAIL single_ready: got %b, expected 01", {bus.req1_ready_o, bus.req0_ready_o});
        end
        sb.push_back('{0, 32'd8, 1'b0});
        tick();
        bus.req0_valid_i = 1'b0;
        #1;
        n_checks++;
        if ({bus.req0_ready_o, bus.rsp0_valid_o, bus.alu_a_o, bus.alu_b_o} !== {1'b0, 1'b0, 32'd5, 32'd3}) begin
            n_fail++;
            $display("FAIL single_exec: ready=%b rsp_valid=%b alu_a=%0d alu_b=%0d, expected 0 0 5 3",
                     bus.req0_ready_o, bus.rsp0_valid_o, bus.alu_a_o, bus.alu_b_o);
        end
        tick();
        n_checks++;
        if ({bus.rsp1_valid_o, bus.rsp0_valid_o} !== 2'b01) begin
            n_fail++;
            $display("FAIL single_latency: rsp_valid=%b two cycles after grant, expected 01",
                     {bus.rsp1_valid_o, bus.rsp0_valid_o});
        end
        e = sb.pop_front();
        $display("txn req%0d data=%0h zero=%0b", e.idx, get_rsp_data(e.idx), get_rsp_zero(e.idx));
        n_checks++;
        if (get_rsp_data(e.idx) !== e.data || get_rsp_zero(e.idx) !== e.zero) begin
            n_fail++;
            $display("FAIL single_data: got %0h/%b, expected %0h/%b", get_rsp_data(e.idx), get_rsp_zero(e.idx), e.data, e.zero);
        end
        n_checks++;
        if ({bus.rsp1_data_o, bus.rsp1_zero_o} !== '0) begin
            n_fail++;
            $display("FAIL single_other_rsp: rsp1 data=%h zero=%b, expected 0", bus.rsp1_data_o, bus.rsp1_zero_o);
        end
        tick();
        n_checks++;
        if (bus.rsp0_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL single_done: rsp0_valid=%b after consume, expected 0", bus.rsp0_valid_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] oa [2];
        logic [DW-1:0] ob [2];
        logic          of [2];
        logic [DW-1:0] ev;
        int            exp_idx;
        bit            ok;
        exp_t          e;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int r = 0; r < 2; r++) begin
            oa[r] = $urandom; ob[r] = $urandom; of[r] = 1'($urandom_range(0, 1));
            drive_req(r, oa[r], ob[r], of[r]);
        end
        exp_idx = 0;
        for (int k = 0; k < 8; k++) begin
            #1;
            n_checks++;
            if ({bus.req1_ready_o, bus.req0_ready_o} !== ((exp_idx == 0) ? 2'b01 : 2'b10)) begin
                n_fail++;
                $display("FAIL rr_grant[%0d]: ready=%b, expected req%0d", k, {bus.req1_ready_o, bus.req0_ready_o}, exp_idx);
            end
            ev = of[exp_idx] ? (oa[exp_idx] - ob[exp_idx]) : (oa[exp_idx] + ob[exp_idx]);
            sb.push_back('{exp_idx, ev, (ev == '0)});
            tick();
            oa[exp_idx] = $urandom; ob[exp_idx] = $urandom; of[exp_idx] = 1'($urandom_range(0, 1));
            drive_req(exp_idx, oa[exp_idx], ob[exp_idx], of[exp_idx]);
            wait_rsp(exp_idx, 4, ok);
            n_checks++;
            if (!ok) begin
                n_fail++;
                $display("FAIL rr_timeout[%0d]: no rsp%0d_valid, expected within 4 cycles", k, exp_idx);
            end else begin
                e = sb.pop_front();
                $display("txn req%0d data=%0h zero=%0b", e.idx, get_rsp_data(e.idx), get_rsp_zero(e.idx));
                n_checks++;
                if (get_rsp_data(e.idx) !== e.data || get_rsp_zero(e.idx) !== e.zero || get_rsp_valid(1 - e.idx) !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rr_data[%0d]: req%0d got %0h/%b, expected %0h/%b", k, e.idx,
                             get_rsp_data(e.idx), get_rsp_zero(e.idx), e.data, e.zero);
                end
            end
            tick();
            exp_idx = 1 - exp_idx;
        end
        sb.delete();
        clear_reqs();
        tick();
    endtask

    task automatic test_backpressure();
        bit   ok;
        exp_t e;
        bus.rsp0_ready_i = 1'b0;
        drive_req(0, 32'd5, 32'd3, 1'b0);
        #1;
        n_checks++;
        if (bus.req0_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_grant: req0_ready=%b, expected 1", bus.req0_ready_o);
        end
        sb.push_back('{0, 32'd8, 1'b0});
        tick();
        bus.req0_valid_i = 1'b0;
        drive_req(1, 32'd9, 32'd9, 1'b0);
        #1;
        n_checks++;
        if (bus.req1_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_exec_ready: req1_ready=%b in EXEC, expected 0", bus.req1_ready_o);
        end
        tick();
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if ({bus.rsp0_valid_o, bus.rsp0_data_o, bus.req1_ready_o} !== {1'b1, 32'd8, 1'b0}) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: valid=%b data=%0d req1_ready=%b, expected 1 8 0",
                         i, bus.rsp0_valid_o, bus.rsp0_data_o, bus.req1_ready_o);
            end
            tick();
        end
        bus.rsp0_ready_i = 1'b1;
        #1;
        n_checks++;
        if ({bus.rsp0_valid_o, bus.req1_ready_o} !== 2'b10) begin
            n_fail++;
            $display("FAIL bp_release: valid=%b req1_ready=%b, expected 1 0", bus.rsp0_valid_o, bus.req1_ready_o);
        end
        e = sb.pop_front();
        $display("txn req%0d data=%0h zero=%0b", e.idx, get_rsp_data(e.idx), get_rsp_zero(e.idx));
        n_checks++;
        if (get_rsp_data(e.idx) !== e.data || get_rsp_zero(e.idx) !== e.zero) begin
            n_fail++;
            $display("FAIL bp_data: got %0h/%b, expected %0h/%b", get_rsp_data(e.idx), get_rsp_zero(e.idx), e.data, e.zero);
        end
        tick();
        n_checks++;
        if (bus.req1_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_next_grant: req1_ready=%b in IDLE, expected 1", bus.req1_ready_o);
        end
        sb.push_back('{1, 32'd18, 1'b0});
        tick();
        bus.req1_valid_i = 1'b0;
        wait_rsp(1, 4, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL bp_req1_timeout: no rsp1_valid, expected within 4 cycles");
        end else begin
            e = sb.pop_front();
            $display("txn req%0d data=%0h zero=%0b", e.idx, get_rsp_data(e.idx), get_rsp_zero(e.idx));
            n_checks++;
            if (get_rsp_data(e.idx) !== e.data || get_rsp_zero(e.idx) !== e.zero) begin
                n_fail++;
                $display("FAIL bp_req1_data: got %0h/%b, expected %0h/%b", get_rsp_data(e.idx), get_rsp_zero(e.idx), e.data, e.zero);
            end
        end
        sb.delete();
        tick();
    endtask

    task automatic test_zero_result();
        bit   ok;
        exp_t e;
        drive_req(1, 32'd7, 32'd7, 1'b1);
        #1;
        n_checks++;
        if ({bus.req1_ready_o, bus.req0_ready_o} !== 2'b10) begin
            n_fail++;
            $display("FAIL zero_grant: ready=%b, expected 10", {bus.req1_ready_o, bus.req0_ready_o});
        end
        sb.push_back('{1, 32'd0, 1'b1});
        tick();
        bus.req1_valid_i = 1'b0;
        wait_rsp(1, 4, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL zero_timeout: no rsp1_valid, expected within 4 cycles");
        end else begin
            e = sb.pop_front();
            $display("txn req%0d data=%0h zero=%0b", e.idx, get_rsp_data(e.idx), get_rsp_zero(e.idx));
            n_checks++;
            if (get_rsp_data(e.idx) !== e.data || get_rsp_zero(e.idx) !== e.zero) begin
                n_fail++;
                $display("FAIL zero_data: got %0h/%b, expected %0h/%b", get_rsp_data(e.idx), get_rsp_zero(e.idx), e.data, e.zero);
            end
            n_checks++;
            if ({bus.rsp0_valid_o, bus.rsp0_data_o, bus.rsp0_zero_o} !== '0) begin
                n_fail++;
                $display("FAIL zero_other_rsp: rsp0 valid=%b data=%h zero=%b, expected 0",
                         bus.rsp0_valid_o, bus.rsp0_data_o, bus.rsp0_zero_o);
            end
        end
        sb.delete();
        tick();
    endtask

    task automatic test_reset_in_exec();
        bit   seen;
        bit   ok;
        exp_t e;
        drive_req(0, 32'd1, 32'd2, 1'b0);
        #1;
        tick();
        bus.req0_valid_i = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({bus.req1_ready_o, bus.req0_ready_o, bus.rsp1_valid_o, bus.rsp0_valid_o,
             bus.alu_a_o, bus.alu_b_o, bus.rsp0_data_o} !== '0) begin
            n_fail++;
            $display("FAIL rst_exec_outputs: ready=%b%b valid=%b%b alu_a=%h alu_b=%h, expected all 0",
                     bus.req1_ready_o, bus.req0_ready_o, bus.rsp1_valid_o, bus.rsp0_valid_o, bus.alu_a_o, bus.alu_b_o);
        end
        tick();
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (bus.rsp0_valid_o || bus.rsp1_valid_o) seen = 1'b1;
            tick();
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_exec_dropped: rsp_valid seen after release=%b, expected 0", seen);
        end
        drive_req(0, 32'd10, 32'd20, 1'b0);
        #1;
        n_checks++;
        if (bus.req0_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_exec_regrant: req0_ready=%b, expected 1", bus.req0_ready_o);
        end
        sb.push_back('{0, 32'd30, 1'b0});
        tick();
        bus.req0_valid_i = 1'b0;
        wait_rsp(0, 4, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL rst_exec_timeout: no rsp0_valid, expected within 4 cycles");
        end else begin
            e = sb.pop_front();
            $display("txn req%0d data=%0h zero=%0b", e.idx, get_rsp_data(e.idx), get_rsp_zero(e.idx));
            n_checks++;
            if (get_rsp_data(e.idx) !== e.data || get_rsp_zero(e.idx) !== e.zero) begin
                n_fail++;
                $display("FAIL rst_exec_data: got %0h/%b, expected %0h/%b", get_rsp_data(e.idx), get_rsp_zero(e.idx), e.data, e.zero);
            end
        end
        sb.delete();
        tick();
    endtask

    task automatic test_operand_stability();
        exp_t e;
        bus.rsp0_ready_i = 1'b0;
        drive_req(0, 32'd100, 32'd50, 1'b1);
        #1;
        sb.push_back('{0, 32'd50, 1'b0});
        tick();
        bus.req0_valid_i = 1'b0;
        bus.req0_a_i = 32'hDEAD_BEEF; bus.req0_b_i = 32'h1234_5678; bus.req0_funct7_i = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({bus.alu_a_o, bus.alu_b_o, bus.alu_funct7_o} !== {32'd100, 32'd50, 1'b1}) begin
                n_fail++;
                $display("FAIL stable_alu[%0d]: alu_a=%0d alu_b=%0d f7=%b, expected 100 50 1",
                         i, bus.alu_a_o, bus.alu_b_o, bus.alu_funct7_o);
            end
            tick();
            bus.req0_a_i = $urandom; bus.req0_b_i = $urandom;
            #1;
        end
        bus.rsp0_ready_i = 1'b1;
        #1;
        e = sb.pop_front();
        $display("txn req%0d data=%0h zero=%0b", e.idx, get_rsp_data(e.idx), get_rsp_zero(e.idx));
        n_checks++;
        if (bus.rsp0_valid_o !== 1'b1 || get_rsp_data(e.idx) !== e.data || get_rsp_zero(e.idx) !== e.zero) begin
            n_fail++;
            $display("FAIL stable_data: valid=%b got %0h/%b, expected 1 %0h/%b",
                     bus.rsp0_valid_o, get_rsp_data(e.idx), get_rsp_zero(e.idx), e.data, e.zero);
        end
        sb.delete();
        clear_reqs();
        tick();
    endtask

    initial begin
        test_reset();
        test_single_req0();
        test_back_to_back();
        test_backpressure();
        test_zero_result();
        test_reset_in_exec();
        test_operand_stability();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
